// File: rtl/mult_sched_pkg.sv
// Shared constants and FSM encoding for the mult_sched block.
package mult_sched_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned RES_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic [1:0] {
        StIdle = S_IDLE,
        StMul  = S_MUL,
        StResp = S_RESP
    } state_e;

endpackage

// File: rtl/mult4x4.sv
// Shared 4x4 unsigned combinational multiplier.
module mult4x4
    import mult_sched_pkg::*;
(
    input  logic [OP_W-1:0]  i_a,
    input  logic [OP_W-1:0]  i_b,
    output logic [RES_W-1:0] o_p
);

    assign o_p = RES_W'(i_a) * RES_W'(i_b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_idx,
    output logic             o_any_grant
);

    logic [ID_W-1:0] w_idx;

    // Scan requesters starting at the pointer, wrapping past N_REQ-1.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'((32'(i_ptr) + k) % N_REQ);
            if (!o_any_grant && i_req[w_idx]) begin
                o_any_grant    = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one 4x4 multiplier between N_REQ requesters.
// Optional per-requester grant counters are enabled with MULT_SCHED_STATS_EN.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [OP_W*N_REQ-1:0]   i_req_a,
    input  logic [OP_W*N_REQ-1:0]   i_req_b,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_resp_valid,
    output logic [ID_W-1:0]         o_resp_id,
    output logic [RES_W-1:0]        o_resp_r,
    input  logic                    i_resp_ready,
    output logic                    o_busy
`ifdef MULT_SCHED_STATS_EN
    ,
    output logic [16*N_REQ-1:0]     o_grant_cnt
`endif
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [OP_W-1:0]  r_a;
    logic [OP_W-1:0]  r_b;
    logic [ID_W-1:0]  r_id;
    logic [RES_W-1:0] r_prod;

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_idx;
    logic             w_any_grant;
    logic             w_accept;
    logic [RES_W-1:0] w_prod;
    logic [ID_W-1:0]  w_ptr_nxt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req       (i_req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    mult4x4 u_mult (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    assign w_ptr_nxt = (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    // Next-state and handshake outputs; reset masks any grant or response in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        o_req_ready  = '0;
        o_resp_valid = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_any_grant) begin
                    w_accept    = 1'b1;
                    o_req_ready = w_grant;
                    w_state_nxt = StMul;
                end
            end
            StMul: begin
                w_state_nxt = StResp;
            end
            StResp: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        if (i_rst) begin
            w_accept     = 1'b0;
            o_req_ready  = '0;
            o_resp_valid = 1'b0;
        end
    end

    // State, pointer, operand and product registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_id    <= '0;
            r_prod  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a   <= i_req_a[OP_W*w_grant_idx +: OP_W];
                r_b   <= i_req_b[OP_W*w_grant_idx +: OP_W];
                r_id  <= w_grant_idx;
                r_ptr <= w_ptr_nxt;
            end
            if (r_state == StMul) begin
                r_prod <= w_prod;
            end
        end
    end

    assign o_resp_id = r_id;
    assign o_resp_r  = r_prod;
    assign o_busy    = (r_state != StIdle);

`ifdef MULT_SCHED_STATS_EN
    logic [16*N_REQ-1:0] r_grant_cnt;

    // Per-requester accept counters, free-running with natural 16-bit wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (w_accept && w_grant[i]) begin
                    r_grant_cnt[16*i +: 16] <= r_grant_cnt[16*i +: 16] + 16'd1;
                end
            end
        end
    end

    assign o_grant_cnt = r_grant_cnt;
`endif

endmodule
